// File: rtl/sram_req_arbiter.sv
// Two-master SRAM-like request arbiter (data over inst) with an in-order owner
// tag FIFO that steers slave responses back to the issuing master.
module sram_req_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata,
  output logic        resp_err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t           state;
  logic [DEPTH-1:0] tag_mem;
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;

  logic full, empty, sel_data, sel_req, s_req_int, accept, pop, head;
  req_t ireq, dreq, sreq;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = tag_mem[rptr];

  // Once stalled the grant is pinned to its owner; only IDLE looks at priority.
  assign sel_data  = (state == HOLD_D) | ((state == IDLE) & data_req);
  assign sel_req   = sel_data ? data_req : inst_req;
  assign s_req_int = sel_req & ~full & resetn;
  assign accept    = s_req_int & s_addr_ok;
  assign pop       = s_data_ok & ~empty & resetn;

  assign ireq = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb, addr: inst_addr, wdata: inst_wdata};
  assign dreq = '{wr: data_wr, size: data_size, wstrb: data_wstrb, addr: data_addr, wdata: data_wdata};
  assign sreq = s_req_int ? (sel_data ? dreq : ireq) : '0;

  assign s_req   = s_req_int;
  assign s_wr    = sreq.wr;
  assign s_size  = sreq.size;
  assign s_wstrb = sreq.wstrb;
  assign s_addr  = sreq.addr;
  assign s_wdata = sreq.wdata;

  assign inst_addr_ok = accept & ~sel_data;
  assign data_addr_ok = accept &  sel_data;
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop &  head;
  assign inst_rdata   = resetn ? s_rdata : '0;
  assign data_rdata   = resetn ? s_rdata : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:           if (s_req_int & ~s_addr_ok) state <= sel_data ? HOLD_D : HOLD_I;
        HOLD_I, HOLD_D: if (accept | ~sel_req) state <= IDLE;
        default:        state <= IDLE;
      endcase
    end
  end

  // A pop never frees room for a push in the same cycle: full is registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_mem  <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      resp_err <= 1'b0;
    end else begin
      if (accept) begin
        tag_mem[wptr] <= sel_data;
        wptr          <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      if (accept & ~pop)      count <= count + CW'(1);
      else if (pop & ~accept) count <= count - CW'(1);
      if (s_data_ok & empty) resp_err <= 1'b1;
    end
  end
endmodule
